// File: rtl/base_ram_pkg.sv
// Shared types and constants for the base RAM arbiter: FSM states,
// bus widths and the requester id (0 = CPU, 1 = UART loader).
package base_ram_pkg;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 32;
    localparam int WAIT_W = 4;

    typedef logic req_id_t;

    localparam req_id_t REQ_0 = 1'b0;
    localparam req_id_t REQ_1 = 1'b1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD       = 3'd1,
        WR_SETUP = 3'd2,
        WR_PULSE = 3'd3,
        WR_HOLD  = 3'd4,
        DONE     = 3'd5
    } state_t;

endpackage

// File: rtl/base_ram_arbiter_if.sv
// Requester handshake and split-tristate SRAM bus of the base RAM arbiter.
// slave: the arbiter itself; master: requesters plus the SRAM data return.
import base_ram_pkg::*;

interface base_ram_arbiter_if;
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              done0;
    logic              done1;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic [ADDR_W-1:0] base_ram_addr;
    logic [DATA_W-1:0] base_ram_dq_o;
    logic              base_ram_dq_oe;
    logic [DATA_W-1:0] base_ram_dq_i;
    logic              base_ram_ce_n;
    logic              base_ram_oe_n;
    logic              base_ram_we_n;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, base_ram_dq_i,
        output done0, done1, rdata, busy, base_ram_addr, base_ram_dq_o,
               base_ram_dq_oe, base_ram_ce_n, base_ram_oe_n, base_ram_we_n
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, base_ram_dq_i,
        input  done0, done1, rdata, busy, base_ram_addr, base_ram_dq_o,
               base_ram_dq_oe, base_ram_ce_n, base_ram_oe_n, base_ram_we_n
    );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way request arbiter.
// BASE_RAM_RR_EN defined  : round-robin, a conflict goes to the requester
//                           that was not served last.
// BASE_RAM_RR_EN undefined: fixed priority, requester 0 always wins and
//                           the last-grant input is ignored.
import base_ram_pkg::*;

module rr_arbiter2 (
    input  logic    req0,
    input  logic    req1,
    input  req_id_t last,
    output req_id_t grant_id,
    output logic    grant_valid
);
    assign grant_valid = req0 | req1;

`ifdef BASE_RAM_RR_EN
    assign grant_id = (req0 && req1) ? req_id_t'(~last) : (req1 ? REQ_1 : REQ_0);
`else
    logic unused_last;
    assign unused_last = last;
    assign grant_id    = req0 ? REQ_0 : (req1 ? REQ_1 : REQ_0);
`endif

endmodule

// File: rtl/base_ram_arbiter.sv
// Shares one asynchronous SRAM between two requesters. Each access is
// latched in IDLE, run through a read or setup/pulse/hold write sequence
// with WAIT_CYCLES extra strobe cycles, and finished by a one-cycle done
// pulse to its owner. All SRAM-side outputs come straight from flops.
// Arbitration policy is selected by the BASE_RAM_RR_EN macro (see rr_arbiter2).
import base_ram_pkg::*;

module base_ram_arbiter #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    base_ram_arbiter_if.slave bus
);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_CYCLES);

    state_t             state_reg, state_next;
    logic [WAIT_W-1:0]  wait_reg, wait_next;
    req_id_t            owner_reg, owner_next;
    req_id_t            last_reg, last_next;
    logic [ADDR_W-1:0]  addr_reg, addr_next;
    logic [DATA_W-1:0]  wdata_reg, wdata_next;
    logic [DATA_W-1:0]  rdata_reg;
    logic               ce_n_reg, oe_n_reg, we_n_reg, dq_oe_reg;
    logic               ce_n_next, oe_n_next, we_n_next, dq_oe_next;
    logic               done0_reg, done1_reg, done0_next, done1_next;
    req_id_t            grant_id;
    logic               grant_valid;
    logic               grant_we;

    rr_arbiter2 u_arb (
        .req0        (bus.req0),
        .req1        (bus.req1),
        .last        (last_reg),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    assign grant_we = (grant_id == REQ_1) ? bus.we1 : bus.we0;

    // Next-state logic and request capture
    always_comb begin
        state_next = state_reg;
        wait_next  = wait_reg;
        owner_next = owner_reg;
        last_next  = last_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    owner_next = grant_id;
                    last_next  = grant_id;
                    addr_next  = (grant_id == REQ_1) ? bus.addr1  : bus.addr0;
                    wdata_next = (grant_id == REQ_1) ? bus.wdata1 : bus.wdata0;
                    if (grant_we) begin
                        state_next = WR_SETUP;
                    end else begin
                        state_next = RD;
                        wait_next  = WAIT_LOAD;
                    end
                end
            end
            RD: begin
                if (wait_reg == '0) state_next = DONE;
                else                wait_next  = wait_reg - 1'b1;
            end
            WR_SETUP: begin
                state_next = WR_PULSE;
                wait_next  = WAIT_LOAD;
            end
            WR_PULSE: begin
                if (wait_reg == '0) state_next = WR_HOLD;
                else                wait_next  = wait_reg - 1'b1;
            end
            WR_HOLD: state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobe and done values for the state being entered, so the flops hold them during it
    always_comb begin
        ce_n_next  = 1'b1;
        oe_n_next  = 1'b1;
        we_n_next  = 1'b1;
        dq_oe_next = 1'b0;
        case (state_next)
            RD: begin
                ce_n_next = 1'b0;
                oe_n_next = 1'b0;
            end
            WR_SETUP, WR_HOLD: begin
                ce_n_next  = 1'b0;
                dq_oe_next = 1'b1;
            end
            WR_PULSE: begin
                ce_n_next  = 1'b0;
                we_n_next  = 1'b0;
                dq_oe_next = 1'b1;
            end
            default: ;
        endcase
        done0_next = (state_next == DONE) && (owner_next == REQ_0);
        done1_next = (state_next == DONE) && (owner_next == REQ_1);
    end

    // FSM state, wait counter and latched access context
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            wait_reg  <= '0;
            owner_reg <= REQ_0;
            last_reg  <= REQ_1;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
            owner_reg <= owner_next;
            last_reg  <= last_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
        end
    end

    // Registered SRAM strobes and done pulses; reset drops the strobes at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ce_n_reg  <= 1'b1;
            oe_n_reg  <= 1'b1;
            we_n_reg  <= 1'b1;
            dq_oe_reg <= 1'b0;
            done0_reg <= 1'b0;
            done1_reg <= 1'b0;
        end else begin
            ce_n_reg  <= ce_n_next;
            oe_n_reg  <= oe_n_next;
            we_n_reg  <= we_n_next;
            dq_oe_reg <= dq_oe_next;
            done0_reg <= done0_next;
            done1_reg <= done1_next;
        end
    end

    // Capture SRAM read data on the edge that leaves RD, hold it otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_reg <= '0;
        end else if (state_reg == RD && state_next == DONE) begin
            rdata_reg <= bus.base_ram_dq_i;
        end
    end

    assign bus.base_ram_addr  = addr_reg;
    assign bus.base_ram_dq_o  = wdata_reg;
    assign bus.base_ram_dq_oe = dq_oe_reg;
    assign bus.base_ram_ce_n  = ce_n_reg;
    assign bus.base_ram_oe_n  = oe_n_reg;
    assign bus.base_ram_we_n  = we_n_reg;
    assign bus.done0          = done0_reg;
    assign bus.done1          = done1_reg;
    assign bus.rdata          = rdata_reg;
    assign bus.busy           = (state_reg != IDLE);

endmodule

// File: tb/tb_base_ram_arbiter.sv
// Directed bench for base_ram_arbiter: dut1 runs WAIT_CYCLES=1, dut0 runs
// WAIT_CYCLES=0. A small SRAM model sits on each bus; addresses below 0x20
// on dut1 are backed by memory, all others return {12'hABC, addr}.
// Status vector layout: {ce_n, oe_n, we_n, dq_oe, done0, done1, busy}.
`timescale 1ns/1ps
module tb_base_ram_arbiter;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    base_ram_arbiter_if b1();
    base_ram_arbiter_if b0();

    base_ram_arbiter #(.WAIT_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    base_ram_arbiter #(.WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));

    logic [31:0] mem1 [0:31];
    logic [6:0]  st1, st0;

    assign st1 = {b1.base_ram_ce_n, b1.base_ram_oe_n, b1.base_ram_we_n, b1.base_ram_dq_oe,
                  b1.done0, b1.done1, b1.busy};
    assign st0 = {b0.base_ram_ce_n, b0.base_ram_oe_n, b0.base_ram_we_n, b0.base_ram_dq_oe,
                  b0.done0, b0.done1, b0.busy};

    assign b1.base_ram_dq_i = b1.base_ram_oe_n ? 32'hDEAD_BEEF :
                              ((b1.base_ram_addr < 20'h20) ? mem1[b1.base_ram_addr[4:0]]
                                                           : {12'hABC, b1.base_ram_addr});
    assign b0.base_ram_dq_i = b0.base_ram_oe_n ? 32'hDEAD_BEEF : {12'hABC, b0.base_ram_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!b1.base_ram_ce_n && !b1.base_ram_we_n && b1.base_ram_dq_oe && b1.base_ram_addr < 20'h20)
            mem1[b1.base_ram_addr[4:0]] <= b1.base_ram_dq_o;
    end

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            checks++;
            if ((!b0.base_ram_oe_n && !b0.base_ram_we_n) || (b0.base_ram_dq_oe && !b0.base_ram_oe_n)
                || (b0.done0 && b0.done1)) begin
                errors++;
                $display("FAIL invariant dut0 @%0t: status %b", $time, st0);
            end
            checks++;
            if ((!b1.base_ram_oe_n && !b1.base_ram_we_n) || (b1.base_ram_dq_oe && !b1.base_ram_oe_n)
                || (b1.done0 && b1.done1)) begin
                errors++;
                $display("FAIL invariant dut1 @%0t: status %b", $time, st1);
            end
        end
    end

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (st1 !== 7'b1110000 || b1.base_ram_addr !== 20'h0 || b1.base_ram_dq_o !== 32'h0 || b1.rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset dut1: status %b addr %h dq_o %h rdata %h, expected 1110000/0/0/0",
                     st1, b1.base_ram_addr, b1.base_ram_dq_o, b1.rdata);
        end
        checks++;
        if (st0 !== 7'b1110000 || b0.base_ram_addr !== 20'h0 || b0.base_ram_dq_o !== 32'h0 || b0.rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset dut0: status %b addr %h dq_o %h rdata %h, expected 1110000/0/0/0",
                     st0, b0.base_ram_addr, b0.base_ram_dq_o, b0.rdata);
        end
        $display("reset: status dut1 %b dut0 %b", st1, st0);
    endtask

    task automatic write1(input logic [19:0] a, input logic [31:0] d, input string tag);
        logic [6:0] exp_w [0:6];
        exp_w = '{7'b1110000, 7'b0111001, 7'b0101001, 7'b0101001, 7'b0111001, 7'b1110011, 7'b1110000};
        @(posedge clk); #1;
        b1.req1 = 1'b1; b1.we1 = 1'b1; b1.addr1 = a; b1.wdata1 = d;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            checks++;
            if (st1 !== exp_w[k]) begin
                errors++;
                $display("FAIL %s T+%0d: status %b expected %b", tag, k, st1, exp_w[k]);
            end
            if (k == 2) begin
                checks++;
                if (b1.base_ram_addr !== a || b1.base_ram_dq_o !== d) begin
                    errors++;
                    $display("FAIL %s bus: addr %h dq_o %h expected %h %h", tag, b1.base_ram_addr, b1.base_ram_dq_o, a, d);
                end
            end
            @(posedge clk); #1;
            if (k == 5) b1.req1 = 1'b0;
        end
        checks++;
        if (mem1[a[4:0]] !== d) begin
            errors++;
            $display("FAIL %s mem: got %h expected %h", tag, mem1[a[4:0]], d);
        end
        $display("%s: write addr %h data %h done", tag, a, d);
    endtask

    task automatic test_write();
        write1(20'h00010, 32'h0000_00A5, "write");
    endtask

    task automatic test_read();
        logic [6:0] exp_r [0:4];
        exp_r = '{7'b1110000, 7'b0010001, 7'b0010001, 7'b1110011, 7'b1110000};
        @(posedge clk); #1;
        b1.req1 = 1'b1; b1.we1 = 1'b0; b1.addr1 = 20'h00010;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (st1 !== exp_r[k]) begin
                errors++;
                $display("FAIL read T+%0d: status %b expected %b", k, st1, exp_r[k]);
            end
            if (k >= 3) begin
                checks++;
                if (b1.rdata !== 32'h0000_00A5) begin
                    errors++;
                    $display("FAIL read rdata T+%0d: got %h expected 000000a5", k, b1.rdata);
                end
            end
            @(posedge clk); #1;
            if (k == 3) b1.req1 = 1'b0;
        end
        $display("read: addr 00010 rdata %h", b1.rdata);
    endtask

    task automatic test_arbitration();
        int order [0:5];
        int exp_o [0:5];
        int n = 0;
        logic drop0, drop1;
`ifdef BASE_RAM_RR_EN
        exp_o = '{0, 1, 0, 1, 0, 1};
`else
        exp_o = '{0, 0, 0, 0, 0, 1};
`endif
        for (int i = 0; i < 6; i++) order[i] = -1;
        @(posedge clk); #1;
        b1.we0 = 1'b0; b1.we1 = 1'b0; b1.addr0 = 20'h00020; b1.addr1 = 20'h00021;
        b1.req0 = 1'b1; b1.req1 = 1'b1;
        for (int c = 0; c < 100 && n < 6; c++) begin
            drop0 = 1'b0;
            drop1 = 1'b0;
            @(negedge clk);
            if (b1.done0 === 1'b1 || b1.done1 === 1'b1) begin
                checks++;
                if (b1.rdata !== (b1.done1 ? 32'hABC0_0021 : 32'hABC0_0020)) begin
                    errors++;
                    $display("FAIL arb rdata #%0d: got %h for requester %0d", n, b1.rdata, b1.done1);
                end
                order[n] = b1.done1 ? 1 : 0;
                if (n >= 4) begin
                    drop0 = b1.done0;
                    drop1 = b1.done1;
                end
                $display("arb: completion %0d to requester %0d", n, order[n]);
                n++;
            end
            @(posedge clk); #1;
            if (drop0) b1.req0 = 1'b0;
            if (drop1) b1.req1 = 1'b0;
        end
        checks++;
        if (n != 6) begin
            errors++;
            $display("FAIL arb timeout: %0d completions, required 6", n);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (order[i] != exp_o[i]) begin
                errors++;
                $display("FAIL arb order[%0d]: got %0d expected %0d", i, order[i], exp_o[i]);
            end
        end
        b1.req0 = 1'b0;
        b1.req1 = 1'b0;
    endtask

    task automatic test_reset_abort();
        @(posedge clk); #1;
        b1.req1 = 1'b1; b1.we1 = 1'b1; b1.addr1 = 20'h00018; b1.wdata1 = 32'h5A5A_0018;
        repeat (2) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (st1 !== 7'b0101001) begin
            errors++;
            $display("FAIL abort pre: status %b expected 0101001", st1);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (st1 !== 7'b1110000) begin
            errors++;
            $display("FAIL abort immediate: status %b expected 1110000", st1);
        end
        b1.req1 = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (st1 !== 7'b1110000) begin
                errors++;
                $display("FAIL abort held: status %b expected 1110000", st1);
            end
        end
        @(posedge clk); #1;
        rst = 1'b1;
        $display("abort: reset during write pulse, reissuing");
        write1(20'h00018, 32'h5A5A_0018, "rewrite");
    endtask

    task automatic test_back_to_back();
        logic [6:0]  exp_b [0:2];
        logic [6:0]  exp_s;
        logic [31:0] exp_d;
        exp_b = '{7'b1110000, 7'b0010001, 7'b1110101};
        @(posedge clk); #1;
        b0.req0 = 1'b1; b0.we0 = 1'b0; b0.addr0 = 20'h00040;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            exp_s = (k == 9) ? 7'b1110000 : exp_b[k % 3];
            checks++;
            if (st0 !== exp_s) begin
                errors++;
                $display("FAIL b2b T+%0d: status %b expected %b", k, st0, exp_s);
            end
            if (k % 3 == 2) begin
                exp_d = 32'hABC0_0040 + 32'(k / 3);
                checks++;
                if (b0.rdata !== exp_d) begin
                    errors++;
                    $display("FAIL b2b rdata T+%0d: got %h expected %h", k, b0.rdata, exp_d);
                end
                $display("b2b: done0 at T+%0d rdata %h", k, b0.rdata);
            end
            @(posedge clk); #1;
            if (k == 2) b0.addr0 = 20'h00041;
            if (k == 5) b0.addr0 = 20'h00042;
            if (k == 8) b0.req0 = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        b1.req0 = 1'b0; b1.req1 = 1'b0; b1.we0 = 1'b0; b1.we1 = 1'b0;
        b1.addr0 = '0; b1.addr1 = '0; b1.wdata0 = '0; b1.wdata1 = '0;
        b0.req0 = 1'b0; b0.req1 = 1'b0; b0.we0 = 1'b0; b0.we1 = 1'b0;
        b0.addr0 = '0; b0.addr1 = '0; b0.wdata0 = '0; b0.wdata1 = '0;
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        test_write();
        test_read();
        test_arbitration();
        test_reset_abort();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
